// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer.
// A seven-state controller that fetches 16-bit instructions, decodes the
// opcode in bits [15:12] and steps through execute, memory and write-back
// phases. It raises one datapath strobe at a time and counts the
// instructions it has completed.
module multicycle_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             imem_ack,
  input  logic [15:0]      imem_data,
  input  logic             mem_ready,
  output logic             imem_req,
  output logic [PC_W-1:0]  pc,
  output logic [15:0]      ir,
  output logic             reg_read,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_en,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t            state_r;
  state_t            state_s;
  logic [PC_W-1:0]   pc_r;
  logic [15:0]       ir_r;
  logic [CNT_W-1:0]  retired_r;
  logic              illegal_r;

  logic              load_ir_s;
  logic              retire_s;
  logic              set_illegal_s;
  logic [3:0]        opcode_s;

  logic              imem_req_s;
  logic              reg_read_s;
  logic              reg_write_s;
  logic              mem_read_s;
  logic              mem_write_s;
  logic              alu_en_s;
  logic              busy_s;
  logic              halted_s;

  assign opcode_s = ir_r[15:12];

  // State register; reset drops any in-flight instruction back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state selection plus the one-cycle events that update the datapath.
  always_comb begin
    state_s       = state_r;
    load_ir_s     = 1'b0;
    retire_s      = 1'b0;
    set_illegal_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          load_ir_s = 1'b1;
          state_s   = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (opcode_s)
          4'h0, 4'h1, 4'h2, 4'h3: state_s = ST_EXEC;
          OP_LOAD, OP_STORE:      state_s = ST_MEM;
          OP_HALT: begin
            retire_s = 1'b1;
            state_s  = ST_HALT;
          end
          default: begin
            // Undefined opcode retires as a NOP and leaves a sticky flag.
            retire_s      = 1'b1;
            set_illegal_s = 1'b1;
            state_s       = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        state_s = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (opcode_s == OP_STORE) begin
            // A store has nothing to write back, so it completes here.
            retire_s = 1'b1;
            state_s  = ST_FETCH;
          end else begin
            state_s = ST_WB;
          end
        end else begin
          state_s = ST_MEM;
        end
      end
      ST_WB: begin
        retire_s = 1'b1;
        state_s  = ST_FETCH;
      end
      ST_HALT: begin
        if (start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Moore strobe decode from the registered state and instruction only.
  always_comb begin
    imem_req_s  = 1'b0;
    reg_read_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    alu_en_s    = 1'b0;
    busy_s      = 1'b1;
    halted_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_FETCH: begin
        imem_req_s = 1'b1;
      end
      ST_DECODE: begin
        if ((opcode_s <= 4'h3) || (opcode_s == OP_STORE)) begin
          reg_read_s = 1'b1;
        end else begin
          reg_read_s = 1'b0;
        end
      end
      ST_EXEC: begin
        alu_en_s = 1'b1;
      end
      ST_MEM: begin
        if (opcode_s == OP_STORE) begin
          mem_write_s = 1'b1;
        end else begin
          mem_read_s = 1'b1;
        end
      end
      ST_WB: begin
        reg_write_s = 1'b1;
      end
      ST_HALT: begin
        busy_s   = 1'b0;
        halted_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Program counter and instruction register move only on an acknowledged fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= '0;
      ir_r <= 16'h0000;
    end else if (load_ir_s) begin
      pc_r <= pc_r + PC_ONE;
      ir_r <= imem_data;
    end else begin
      pc_r <= pc_r;
      ir_r <= ir_r;
    end
  end

  // Retired-instruction counter; wraps silently at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= '0;
    end else if (retire_s) begin
      retired_r <= retired_r + CNT_ONE;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Sticky undefined-opcode flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if (set_illegal_s) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign imem_req  = imem_req_s;
  assign reg_read  = reg_read_s;
  assign reg_write = reg_write_s;
  assign mem_read  = mem_read_s;
  assign mem_write = mem_write_s;
  assign alu_en    = alu_en_s;
  assign busy      = busy_s;
  assign halted    = halted_s;
  assign pc        = pc_r;
  assign ir        = ir_r;
  assign retired   = retired_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer.
// Each instruction's expected timing, strobe counts and resulting pc,
// retired count and illegal flag are queued when it is driven. They are
// compared after the instruction has finished. The counter is built 8 bits
// wide so that the wrap from 255 to 0 happens within the run.
module tb_multicycle_sequencer;

  localparam int PC_W  = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             imem_ack;
  logic [15:0]      imem_data;
  logic             mem_ready;
  logic             imem_req;
  logic [PC_W-1:0]  pc;
  logic [15:0]      ir;
  logic             reg_read;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             alu_en;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  typedef struct {
    int               cycles;
    int               n_req;
    int               n_rd;
    int               n_alu;
    int               n_mr;
    int               n_mw;
    int               n_wr;
    logic [15:0]      ir;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] ret;
    logic             ill;
    logic             is_halt;
  } exp_t;

  exp_t sb_q[$];

  int total_cnt;
  int bad_cnt;

  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_ret;
  logic             m_ill;

  multicycle_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .mem_ready (mem_ready),
    .imem_req  (imem_req),
    .pc        (pc),
    .ir        (ir),
    .reg_read  (reg_read),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .alu_en    (alu_en),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Assert start for one edge; the bench is left at the first FETCH cycle.
  task automatic do_start(input logic keep);
    start = 1'b1;
    @(negedge clk);
    if (!keep) start = 1'b0;
    check_val("fetch_entry_req", {31'd0, imem_req}, 32'd1);
    check_val("fetch_entry_pc", {24'd0, pc}, {24'd0, m_pc});
  endtask

  // Drive one instruction from its first FETCH cycle; check once it is done.
  task automatic run_instr(input logic [15:0] data, input int ack_dly, input int mem_dly);
    exp_t e;
    exp_t o;
    logic [3:0] op;
    logic is_alu, is_ld, is_st, is_halt, is_ill;
    int n_req, n_rd, n_alu, n_mr, n_mw, n_wr, pc_bad, multi;
    op      = data[15:12];
    is_alu  = (op <= 4'h3);
    is_ld   = (op == 4'h4);
    is_st   = (op == 4'h5);
    is_halt = (op == 4'hF);
    is_ill  = !(is_alu || is_ld || is_st || is_halt);
    e.cycles  = ack_dly + ((is_alu || is_ld) ? 4 : (is_st ? 3 : 2)) + ((is_ld || is_st) ? mem_dly : 0);
    e.n_req   = ack_dly + 1;
    e.n_rd    = (is_alu || is_st) ? 1 : 0;
    e.n_alu   = is_alu ? 1 : 0;
    e.n_mr    = is_ld ? mem_dly + 1 : 0;
    e.n_mw    = is_st ? mem_dly + 1 : 0;
    e.n_wr    = (is_alu || is_ld) ? 1 : 0;
    e.ir      = data;
    e.pc      = m_pc + 8'd1;
    e.ret     = m_ret + 8'd1;
    e.ill     = m_ill | is_ill;
    e.is_halt = is_halt;
    sb_q.push_back(e);
    n_req = 0; n_rd = 0; n_alu = 0; n_mr = 0; n_mw = 0; n_wr = 0; pc_bad = 0; multi = 0;
    imem_data = data;
    for (int c = 0; c < e.cycles; c++) begin
      n_req += int'(imem_req);
      n_rd  += int'(reg_read);
      n_alu += int'(alu_en);
      n_mr  += int'(mem_read);
      n_mw  += int'(mem_write);
      n_wr  += int'(reg_write);
      if (imem_req && (pc !== m_pc)) pc_bad++;
      if ((int'(reg_write) + int'(mem_read) + int'(mem_write)) > 1) multi++;
      imem_ack  = (c == ack_dly);
      mem_ready = (c >= ack_dly + 2 + mem_dly);
      @(negedge clk);
    end
    imem_ack  = 1'b0;
    mem_ready = 1'b0;
    o = sb_q.pop_front();
    check_val("n_imem_req", n_req, o.n_req);
    check_val("n_reg_read", n_rd, o.n_rd);
    check_val("n_alu_en", n_alu, o.n_alu);
    check_val("n_mem_read", n_mr, o.n_mr);
    check_val("n_mem_write", n_mw, o.n_mw);
    check_val("n_reg_write", n_wr, o.n_wr);
    check_val("pc_held_in_fetch", pc_bad, 32'd0);
    check_val("strobe_exclusive", multi, 32'd0);
    check_val("ir", {16'd0, ir}, {16'd0, o.ir});
    check_val("pc", {24'd0, pc}, {24'd0, o.pc});
    check_val("retired", {24'd0, retired}, {24'd0, o.ret});
    check_val("illegal", {31'd0, illegal}, {31'd0, o.ill});
    if (o.is_halt) begin
      check_val("halted", {31'd0, halted}, 32'd1);
      check_val("busy_in_halt", {31'd0, busy}, 32'd0);
    end else begin
      check_val("next_fetch", {31'd0, imem_req}, 32'd1);
    end
    m_pc  = o.pc;
    m_ret = o.ret;
    m_ill = o.ill;
  endtask

  // Watchdog: a run that never ends still reports before stopping.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    m_pc  = 8'd0;
    m_ret = 8'd0;
    m_ill = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    mem_ready = 1'b0;

    // Reset values while reset is held.
    #1;
    check_val("rst_pc", {24'd0, pc}, 32'd0);
    check_val("rst_ir", {16'd0, ir}, 32'd0);
    check_val("rst_retired", {24'd0, retired}, 32'd0);
    check_val("rst_illegal", {31'd0, illegal}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    check_val("rst_imem_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("idle_hold_busy", {31'd0, busy}, 32'd0);
    check_val("idle_hold_req", {31'd0, imem_req}, 32'd0);

    // Reset asserted between edges while a load waits in MEM.
    do_start(1'b0);
    imem_data = 16'h4000;
    imem_ack  = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check_val("abort_mem_read_pre", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    check_val("abort_mem_read_held", {31'd0, mem_read}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_mem_read", {31'd0, mem_read}, 32'd0);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_retired", {24'd0, retired}, 32'd0);
    check_val("abort_pc", {24'd0, pc}, 32'd0);
    check_val("abort_ir", {16'd0, ir}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("abort_idle", {31'd0, busy}, 32'd0);

    // ALU op with start held high throughout (ignored while busy).
    do_start(1'b1);
    run_instr(16'h0123, 0, 0);
    start = 1'b0;
    // Load with a slow memory, store with a slow fetch, then an illegal op.
    run_instr(16'h4000, 0, 3);
    run_instr(16'h5000, 2, 0);
    run_instr(16'h9000, 0, 0);
    run_instr(16'h2abc, 1, 0);
    run_instr(16'h5123, 0, 1);
    run_instr(16'h4321, 3, 2);

    // Halt, stay halted without start, then resume at the next address.
    run_instr(16'hF000, 0, 0);
    repeat (2) @(negedge clk);
    check_val("halt_hold", {31'd0, halted}, 32'd1);
    do_start(1'b0);
    run_instr(16'h3fff, 0, 0);

    // Walk pc to 0xFF with NOPs, halt there; the fetch wraps pc to 0.
    while (m_pc != 8'hFF) run_instr(16'h9000, 0, 0);
    run_instr(16'hF000, 0, 0);
    check_val("pc_wrapped", {24'd0, pc}, 32'd0);
    do_start(1'b0);
    run_instr(16'h1000, 0, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
